fetch_queue: RTL and testbench

Parametrised instruction-fetch front end with a prefetch buffer, sitting between the instruction bus and the decode stage. Holds the fetch PC, issues one outstanding request at a time on the ibus, buffers returned instructions with their PCs in a DEPTH-entry FIFO, and presents them to decode over a valid/ready handshake. A redirect input (branch/jump/exception) flushes the buffer, discards any in-flight response and restarts fetch at a new PC. Replaces the free-running pc/fetch/IF-ID register path.

---
 rtl/fetch_queue_if.sv | 22 ++
 rtl/fetch_queue.sv | 83 ++++++++
 tb/tb_fetch_queue.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/fetch_queue_if.sv
// fetch_queue_if: ibus request/response, redirect and decode handshake of the fetch front end
interface fetch_queue_if #(parameter int DEPTH = 4);
  logic ireq_valid;
  logic [63:0] ireq_addr;
  logic iresp_data_ok;
  logic [31:0] iresp_data;
  logic redirect_valid;
  logic [63:0] redirect_pc;
  logic out_valid;
  logic out_ready;
  logic [63:0] out_pc;
  logic [31:0] out_instr;
  logic [$clog2(DEPTH+1)-1:0] out_count;
  modport master(
    output ireq_valid, ireq_addr, out_valid, out_pc, out_instr, out_count,
    input iresp_data_ok, iresp_data, redirect_valid, redirect_pc, out_ready
  );
  modport slave(
    input ireq_valid, ireq_addr, out_valid, out_pc, out_instr, out_count,
    output iresp_data_ok, iresp_data, redirect_valid, redirect_pc, out_ready
  );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: single-outstanding ibus fetcher with DEPTH-entry prefetch FIFO and redirect flush.
// FETCH_QUEUE_BYPASS_EN: forward a response straight to decode when the FIFO is empty.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input logic clk,
  input logic reset,
  fetch_queue_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_t;
  state_t state;
  logic [63:0] fetch_pc, fetch_nxt, addr_q;
  logic [63:0] pc_q [DEPTH];
  logic [31:0] instr_q [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [CW-1:0] cnt, cnt_nxt;
  logic req_q, resp, byp, push, pop, more, hold;
  assign resp = state == REQ && bus.iresp_data_ok && !bus.redirect_valid;
`ifdef FETCH_QUEUE_BYPASS_EN
  assign byp = resp && cnt == '0;
`else
  assign byp = 1'b0;
`endif
  assign push = resp && !(byp && bus.out_ready);
  assign pop = !bus.redirect_valid && cnt != '0 && bus.out_ready;
  assign cnt_nxt = bus.redirect_valid ? '0 : cnt + CW'(push) - CW'(pop);
  assign more = resp && cnt_nxt < CW'(DEPTH);
  assign fetch_nxt = bus.redirect_valid ? bus.redirect_pc : resp ? fetch_pc + 64'd4 : fetch_pc;
  assign hold = state != IDLE && !bus.iresp_data_ok;
  assign bus.ireq_valid = req_q;
  assign bus.ireq_addr = addr_q;
  assign bus.out_valid = !bus.redirect_valid && (cnt != '0 || byp);
  assign bus.out_pc = byp ? fetch_pc : cnt != '0 ? pc_q[rptr] : '0;
  assign bus.out_instr = byp ? bus.iresp_data : cnt != '0 ? instr_q[rptr] : '0;
  assign bus.out_count = cnt;
  // the bus address stays frozen while a request is outstanding, even across redirects
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      req_q <= 1'b0;
      fetch_pc <= RESET_PC;
      addr_q <= RESET_PC;
    end else begin
      fetch_pc <= fetch_nxt;
      addr_q <= hold ? addr_q : fetch_nxt;
      case (state)
        IDLE: if (bus.redirect_valid || cnt < CW'(DEPTH)) begin
          state <= REQ;
          req_q <= 1'b1;
        end
        REQ: if (bus.iresp_data_ok) begin
          state <= more ? REQ : IDLE;
          req_q <= more;
        end else if (bus.redirect_valid) state <= DISCARD;
        DISCARD: if (bus.iresp_data_ok) begin
          state <= IDLE;
          req_q <= 1'b0;
        end
        default: begin
          state <= IDLE;
          req_q <= 1'b0;
        end
      endcase
    end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wptr <= '0;
      rptr <= '0;
      cnt <= '0;
    end else begin
      wptr <= bus.redirect_valid ? '0 : wptr + AW'(push);
      rptr <= bus.redirect_valid ? '0 : rptr + AW'(pop);
      cnt <= cnt_nxt;
    end
  always_ff @(posedge clk)
    if (push) begin
      pc_q[wptr] <= fetch_pc;
      instr_q[wptr] <= bus.iresp_data;
    end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed vectors for fill, full/drain, redirect and async reset of fetch_queue
module tb_fetch_queue;
  localparam int DEPTH = 4;
  localparam logic [63:0] RST = 64'h0000_0000_8000_0000;
  localparam logic [63:0] R1 = 64'h0000_0000_8000_1000;
  localparam logic [63:0] R2 = 64'h0000_0000_8000_2000;
`ifdef FETCH_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [63:0] a, e;
  int tests = 0;
  int fails = 0;
  fetch_queue_if #(.DEPTH(DEPTH)) bus();
  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RST)) u_dut (.clk(clk), .reset(reset), .bus(bus.master));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic cyc(input logic dok, input logic [31:0] d, input logic rv, input logic [63:0] rpc, input logic rdy);
    @(negedge clk);
    bus.iresp_data_ok = dok;
    bus.iresp_data = d;
    bus.redirect_valid = rv;
    bus.redirect_pc = rpc;
    bus.out_ready = rdy;
    #1;
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_req"}, 64'(bus.ireq_valid), 64'd0);
    chk({tag, "_addr"}, bus.ireq_addr, RST);
    chk({tag, "_valid"}, 64'(bus.out_valid), 64'd0);
    chk({tag, "_pc"}, bus.out_pc, 64'd0);
    chk({tag, "_instr"}, 64'(bus.out_instr), 64'd0);
    chk({tag, "_cnt"}, 64'(bus.out_count), 64'd0);
  endtask
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask
  initial begin
    bus.iresp_data_ok = 1'b0;
    bus.iresp_data = '0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;
    bus.out_ready = 1'b0;
    #1 reset = 1'b0;
    cyc(0, 0, 0, 0, 0);
    chk_reset("rst");
    @(negedge clk);
    reset = 1'b1;
    #1 chk("pre_req", 64'(bus.ireq_valid), 64'd0);
    for (int k = 0; k < 6; k++) begin
      a = RST + 64'(4 * k);
      cyc(1, a[31:0], 0, 0, 1);
      e = BYP ? a : k > 0 ? a - 64'd4 : 64'd0;
      chk("a_req", 64'(bus.ireq_valid), 64'd1);
      chk("a_addr", bus.ireq_addr, a);
      chk("a_valid", 64'(bus.out_valid), 64'(BYP || k > 0));
      chk("a_pc", bus.out_pc, e);
      chk("a_instr", 64'(bus.out_instr), {32'd0, e[31:0]});
      chk("a_cnt", 64'(bus.out_count), (BYP || k == 0) ? 64'd0 : 64'd1);
    end
    do_reset();
    for (int k = 0; k < 4; k++) begin
      a = RST + 64'(4 * k);
      cyc(1, a[31:0], 0, 0, 0);
      chk("b_addr", bus.ireq_addr, a);
      chk("b_cnt", 64'(bus.out_count), 64'(k));
    end
    cyc(0, 0, 0, 0, 0);
    chk("b_full_req", 64'(bus.ireq_valid), 64'd0);
    chk("b_full_cnt", 64'(bus.out_count), 64'd4);
    chk("b_full_valid", 64'(bus.out_valid), 64'd1);
    for (int j = 0; j < 4; j++) begin
      a = RST + 64'(4 * j);
      cyc(0, 0, 0, 0, 1);
      chk("b_pop_pc", bus.out_pc, a);
      chk("b_pop_instr", 64'(bus.out_instr), {32'd0, a[31:0]});
      chk("b_pop_cnt", 64'(bus.out_count), 64'(4 - j));
    end
    cyc(0, 0, 0, 0, 1);
    chk("b_resume_cnt", 64'(bus.out_count), 64'd0);
    chk("b_resume_req", 64'(bus.ireq_valid), 64'd1);
    chk("b_resume_addr", bus.ireq_addr, RST + 64'h10);
    cyc(0, 0, 1, R1, 1);
    chk("c_redir_valid", 64'(bus.out_valid), 64'd0);
    for (int k = 0; k < 2; k++) begin
      cyc(0, 0, 0, 0, 1);
      chk("c_hold_req", 64'(bus.ireq_valid), 64'd1);
      chk("c_hold_addr", bus.ireq_addr, RST + 64'h10);
    end
    cyc(1, 32'hdead_beef, 0, 0, 1);
    chk("c_drop_addr", bus.ireq_addr, RST + 64'h10);
    chk("c_drop_valid", 64'(bus.out_valid), 64'd0);
    cyc(0, 0, 0, 0, 0);
    chk("c_idle_req", 64'(bus.ireq_valid), 64'd0);
    chk("c_idle_addr", bus.ireq_addr, R1);
    chk("c_idle_valid", 64'(bus.out_valid), 64'd0);
    chk("c_idle_cnt", 64'(bus.out_count), 64'd0);
    a = R1;
    cyc(1, a[31:0], 0, 0, 0);
    chk("c_new_req", 64'(bus.ireq_valid), 64'd1);
    chk("c_new_addr", bus.ireq_addr, R1);
    chk("c_new_valid", 64'(bus.out_valid), 64'(BYP));
    cyc(1, 32'h1234_5678, 1, R2, 1);
    chk("d_cnt", 64'(bus.out_count), 64'd1);
    chk("d_pc", bus.out_pc, R1);
    chk("d_valid", 64'(bus.out_valid), 64'd0);
    cyc(0, 0, 0, 0, 0);
    chk("d_post_cnt", 64'(bus.out_count), 64'd0);
    chk("d_post_req", 64'(bus.ireq_valid), 64'd0);
    chk("d_post_addr", bus.ireq_addr, R2);
    chk("d_post_valid", 64'(bus.out_valid), 64'd0);
    for (int k = 0; k < 3; k++) begin
      a = R2 + 64'(4 * k);
      cyc(1, a[31:0], 0, 0, 0);
      chk("e_addr", bus.ireq_addr, a);
    end
    cyc(0, 0, 0, 0, 0);
    chk("e_cnt", 64'(bus.out_count), 64'd3);
    chk("e_pc", bus.out_pc, R2);
    #2;
    reset = 1'b0;
    bus.iresp_data_ok = 1'b1;
    bus.iresp_data = 32'hbad0_bad0;
    #1 chk_reset("e_rst");
    @(negedge clk);
    reset = 1'b1;
    #1 chk("e_stray_req", 64'(bus.ireq_valid), 64'd0);
    a = RST;
    cyc(1, a[31:0], 0, 0, 1);
    chk("e_first_req", 64'(bus.ireq_valid), 64'd1);
    chk("e_first_addr", bus.ireq_addr, RST);
    chk("e_first_cnt", 64'(bus.out_count), 64'd0);
    chk("e_first_valid", 64'(bus.out_valid), 64'(BYP));
    cyc(0, 0, 0, 0, 1);
    chk("e_out_valid", 64'(bus.out_valid), 64'(!BYP));
    chk("e_out_pc", bus.out_pc, BYP ? 64'd0 : RST);
    chk("e_out_cnt", 64'(bus.out_count), BYP ? 64'd0 : 64'd1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
